uart_word_loader: RTL and testbench

Sits directly downstream of the UART receiver and consumes its byte stream (data byte, one-cycle ready pulse, framing-error flag). It assembles a little-endian 32-bit length header and then that many little-endian 32-bit words. Each word is written into instruction/data memory through a valid/ready write port. This is the boot-time program loader that fills memory before the core is released.

---
 rtl/uart_word_loader.sv | 171 +++++++++++++++++
 tb/tb_uart_word_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_loader.sv
// Boot-time program loader: takes a little-endian word count followed by that
// many little-endian 32-bit words from the UART byte stream and writes them to memory.
module uart_word_loader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  input  logic                  rx_ferr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_DONE,
    S_ERR
  } state_e;

  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t       BASE  = addr_t'(BASE_ADDR);
  localparam logic [32:0] MAX_N = 33'(1) << ADDR_WIDTH;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  cnt_t        count_q, count_d;
  cnt_t        asm_q, asm_d;
  cnt_t        loaded_q, loaded_d;
  logic        mem_we_q, mem_we_d;
  addr_t       addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] shifted;
  logic        xfer;

  always_comb begin
    shifted = shift_q;
    shifted[{idx_q, 3'b000} +: 8] = rx_data;
  end

  assign xfer = mem_we_q & mem_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    count_d  = count_q;
    asm_d    = asm_q;
    loaded_d = loaded_q;
    mem_we_d = mem_we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d  = S_HEADER;
          idx_d    = '0;
          shift_d  = '0;
          count_d  = '0;
          asm_d    = '0;
          loaded_d = '0;
          mem_we_d = 1'b0;
          addr_d   = BASE;
        end
      end

      S_HEADER: begin
        if (rx_ready) begin
          if (rx_ferr) begin
            state_d = S_ERR;
          end else begin
            shift_d = shifted;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              shift_d = '0;
              if (shifted == '0) begin
                state_d = S_DONE;
              end else if ({1'b0, shifted} > MAX_N) begin
                state_d = S_ERR;
              end else begin
                count_d = cnt_t'(shifted);
                state_d = S_DATA;
              end
            end
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          mem_we_d = 1'b0;
          addr_d   = addr_q + addr_t'(1);
          loaded_d = loaded_q + cnt_t'(1);
        end
        if (loaded_q == count_q) begin
          state_d = S_DONE;
        end else if (rx_ready) begin
          if (rx_ferr) begin
            state_d  = S_ERR;
            mem_we_d = 1'b0;
          end else if (asm_q != count_q) begin
            // A word completing alongside the previous transfer is legal; only a still-stalled write overruns.
            shift_d = shifted;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              shift_d = '0;
              asm_d   = asm_q + cnt_t'(1);
              if (mem_we_q && !mem_ready) begin
                state_d  = S_ERR;
                mem_we_d = 1'b0;
              end else begin
                mem_we_d = 1'b1;
                wdata_d  = shifted;
              end
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      count_q  <= '0;
      asm_q    <= '0;
      loaded_q <= '0;
      mem_we_q <= 1'b0;
      addr_q   <= BASE;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      asm_q    <= asm_d;
      loaded_q <= loaded_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = loaded_q;
  assign busy         = (state_q == S_HEADER) || (state_q == S_DATA);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader: directed scenarios plus randomized
// loads, checked against an expected list of (address, word) writes.
module tb_uart_word_loader;

  localparam int unsigned AW   = 4;
  localparam int unsigned BASE = 0;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          rx_ferr;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  uart_word_loader #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_ferr     (rx_ferr),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory side: 0 = always ready, 1 = random with low runs of at most 3 cycles, 2 = stalled
  int unsigned ready_mode = 0;
  initial begin
    int unsigned low_run = 0;
    logic r;
    mem_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: r = 1'b1;
        1: r = (low_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        default: r = 1'b0;
      endcase
      low_run = r ? 0 : low_run + 1;
      mem_ready = r;
    end
  end

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int unsigned we_cycles = 0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mem_we === 1'b1) we_cycles++;
      if (mem_we === 1'b1 && mem_ready === 1'b1) begin
        wr_addr.push_back(32'(mem_addr));
        wr_data.push_back(mem_wdata);
      end
    end
  end

  logic [31:0] exp_words[$];

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    we_cycles = 0;
  endtask

  // Tasks below are entered at a falling edge and return at a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ferr, input int unsigned gap);
    rx_data  = b;
    rx_ready = 1'b1;
    rx_ferr  = ferr;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_ferr  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0, gap);
  endtask

  task automatic wait_flag(input string tag, input logic want_err, input int unsigned budget);
    for (int i = 0; i < budget; i++) begin
      if ((want_err ? err : done) === 1'b1) break;
      @(negedge clk);
    end
    check(tag, 32'(want_err ? err : done), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int unsigned n);
    check({tag, "_nwrites"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], (BASE + i) % DEPTH);
      check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_words[i]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), BASE);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        stable;
    int unsigned n;
    int unsigned gap;

    rstn = 1'b0; start = 1'b0; rx_data = '0; rx_ready = 1'b0; rx_ferr = 1'b0;
    #2;
    check_idle_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Nominal two-word load
    clear_log();
    exp_words = '{32'h1234_5678, 32'hDEAD_BEEF};
    pulse_start();
    send_word(32'd2, 1);
    foreach (exp_words[i]) send_word(exp_words[i], 1);
    wait_flag("nom_done", 1'b0, 50);
    check_writes("nom", 2);
    check("nom_we_cycles", we_cycles, 32'd2);
    check("nom_words", 32'(words_loaded), 32'd2);
    check("nom_err", 32'(err), 32'd0);

    // Zero-length header finishes the cycle after the fourth byte
    clear_log();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0, 1);
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_done_early", 32'(done), 32'd0);
    send_byte(8'h00, 1'b0, 0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("zero_we_cycles", we_cycles, 32'd0);

    // Backpressure: a pending write holds address and data while stalled
    clear_log();
    ready_mode = 2;
    exp_words = '{$urandom(), $urandom()};
    @(negedge clk);
    pulse_start();
    send_word(32'd2, 1);
    send_word(exp_words[0], 0);
    check("bp_we", 32'(mem_we), 32'd1);
    check("bp_addr", 32'(mem_addr), BASE);
    check("bp_wdata", mem_wdata, exp_words[0]);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (mem_we !== 1'b1 || 32'(mem_addr) != BASE || mem_wdata !== exp_words[0]) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    ready_mode = 0;
    send_word(exp_words[1], 1);
    wait_flag("bp_done", 1'b0, 50);
    check_writes("bp", 2);
    check("bp_words", 32'(words_loaded), 32'd2);

    // Overrun: second word completes while the first is still stalled
    clear_log();
    ready_mode = 2;
    @(negedge clk);
    pulse_start();
    send_word(32'd2, 1);
    send_word($urandom(), 1);
    send_word($urandom(), 1);
    wait_flag("ovr_err", 1'b1, 5);
    check("ovr_words", 32'(words_loaded), 32'd0);
    check("ovr_we", 32'(mem_we), 32'd0);
    check("ovr_nwrites", wr_addr.size(), 32'd0);
    ready_mode = 0;

    // Framing error on the third data byte, then a clean reload
    clear_log();
    pulse_start();
    send_word(32'd1, 1);
    send_byte(8'h11, 1'b0, 1);
    send_byte(8'h22, 1'b0, 1);
    send_byte(8'h33, 1'b1, 0);
    check("ferr_err", 32'(err), 32'd1);
    send_byte(8'h44, 1'b0, 3);
    check("ferr_nwrites", wr_addr.size(), 32'd0);
    clear_log();
    exp_words = '{$urandom()};
    pulse_start();
    send_word(32'd1, 1);
    send_word(exp_words[0], 1);
    wait_flag("reload_done", 1'b0, 20);
    check_writes("reload", 1);
    check("reload_words", 32'(words_loaded), 32'd1);

    // Oversize header, then the largest legal count fills every address
    clear_log();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'(DEPTH + 1 >> (8 * i)), 1'b0, 1);
    send_byte(8'h00, 1'b0, 0);
    check("over_err", 32'(err), 32'd1);
    clear_log();
    exp_words.delete();
    for (int i = 0; i < DEPTH; i++) exp_words.push_back($urandom());
    pulse_start();
    send_word(DEPTH, 1);
    foreach (exp_words[i]) send_word(exp_words[i], 1);
    wait_flag("full_done", 1'b0, 50);
    check_writes("full", DEPTH);
    check("full_words", 32'(words_loaded), DEPTH);

    // Asynchronous reset while a write is pending
    clear_log();
    ready_mode = 2;
    @(negedge clk);
    pulse_start();
    send_word(32'd2, 1);
    send_word(32'hCAFE_F00D, 0);
    check("arst_we_before", 32'(mem_we), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_idle_outputs("arst");
    @(negedge clk);
    rstn = 1'b1;
    ready_mode = 0;
    clear_log();
    send_word(32'd1, 1);
    send_word(32'h0BAD_0BAD, 1);
    check("arst_nwrites", wr_addr.size(), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);

    // Randomized loads under random bounded backpressure
    for (int t = 0; t < 6; t++) begin
      clear_log();
      ready_mode = 1;
      n   = $urandom_range(1, DEPTH);
      gap = $urandom_range(3, 6);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom());
      pulse_start();
      send_word(n, gap);
      foreach (exp_words[i]) begin
        send_word(exp_words[i], gap);
        if (i == 0) pulse_start();
      end
      wait_flag($sformatf("rnd%0d_done", t), 1'b0, 50);
      check_writes($sformatf("rnd%0d", t), n);
      check($sformatf("rnd%0d_words", t), 32'(words_loaded), n);
      check($sformatf("rnd%0d_err", t), 32'(err), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
